clock_ratio_meter: RTL and testbench

Measures a monitored clock against the system clock, counting `clk` cycles over a fixed window of monitored-clock periods and reporting the period total and high-time total. It sits at the output of the integer-N clock divider and closes the loop on it: firmware programs a divide factor, then reads back the measured ratio and duty to confirm it. Results return over a valid/ack handshake, with timeout and saturation flags.

---
 rtl/clock_ratio_meter_if.sv | 24 ++
 rtl/clock_ratio_meter.sv | 140 ++++++++++++++
 tb/tb_clock_ratio_meter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_ratio_meter_if.sv
// Request/result handshake between firmware-side consumer and the clock ratio meter.
// The meter drives the slave side; the consumer uses the master side.
interface clock_ratio_meter_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             ack;
    logic             busy;
    logic             result_valid;
    logic [CNT_W-1:0] period_total;
    logic [CNT_W-1:0] high_total;
    logic             timeout;
    logic             saturated;

    modport master (
        output start, ack,
        input  busy, result_valid, period_total, high_total, timeout, saturated
    );

    modport slave (
        input  start, ack,
        output busy, result_valid, period_total, high_total, timeout, saturated
    );
endinterface

// File: rtl/clock_ratio_meter.sv
// Counts clk cycles across 2^WIN_LOG2 monitored-clock periods, plus cycles spent high,
// and returns the totals over a valid/ack handshake with timeout and saturation flags.
module clock_ratio_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WIN_LOG2 = 2,
    parameter int unsigned TO_W     = 12
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  mon_clk,
    clock_ratio_meter_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StArm, StMeas, StDone} state_e;

    localparam logic [WIN_LOG2:0] WinEdges = (WIN_LOG2 + 1)'(1 << WIN_LOG2);

    state_e              state_q, state_d;
    logic                m1, m2, m3;
    logic                rise;
    logic [CNT_W-1:0]    per_q, per_d, hi_q, hi_d;
    logic [CNT_W-1:0]    per_inc, hi_inc;
    logic [CNT_W-1:0]    per_tot_q, per_tot_d, hi_tot_q, hi_tot_d;
    logic [WIN_LOG2:0]   edges_q, edges_d, edges_inc;
    logic [TO_W-1:0]     to_q, to_d;
    logic                to_full;
    logic                sat_q, sat_d, sat_nx;
    logic                tmo_q, tmo_d, satf_q, satf_d;

    assign rise      = m2 & ~m3;
    assign to_full   = (to_q == '1);
    // Accumulators hold at all-ones instead of wrapping.
    assign per_inc   = (per_q == '1) ? per_q : per_q + CNT_W'(1);
    assign hi_inc    = (hi_q == '1) ? hi_q : hi_q + CNT_W'(m2);
    assign edges_inc = edges_q + (WIN_LOG2 + 1)'(rise);
    assign sat_nx    = sat_q | (per_inc == '1) | (hi_inc == '1);

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        edges_d   = edges_q;
        to_d      = to_q;
        sat_d     = sat_q;
        tmo_d     = tmo_q;
        satf_d    = satf_q;
        per_tot_d = per_tot_q;
        hi_tot_d  = hi_tot_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StArm;
                    per_d   = '0;
                    hi_d    = '0;
                    edges_d = '0;
                    to_d    = '0;
                    sat_d   = 1'b0;
                    tmo_d   = 1'b0;
                    satf_d  = 1'b0;
                end
            end
            StArm: begin
                if (to_full) begin
                    state_d   = StDone;
                    tmo_d     = 1'b1;
                    per_tot_d = per_q;
                    hi_tot_d  = hi_q;
                    satf_d    = sat_q;
                end else if (rise) begin
                    // The arming rise only opens the window; it is not counted.
                    state_d = StMeas;
                    per_d   = '0;
                    hi_d    = '0;
                    edges_d = '0;
                    to_d    = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StMeas: begin
                per_d   = per_inc;
                hi_d    = hi_inc;
                sat_d   = sat_nx;
                edges_d = edges_inc;
                to_d    = rise ? '0 : to_q + TO_W'(1);
                if (to_full || (rise && edges_inc == WinEdges)) begin
                    state_d   = StDone;
                    tmo_d     = to_full;
                    per_tot_d = per_inc;
                    hi_tot_d  = hi_inc;
                    satf_d    = sat_nx;
                end
            end
            StDone: begin
                if (bus.ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= StIdle;
            m1        <= 1'b0;
            m2        <= 1'b0;
            m3        <= 1'b0;
            per_q     <= '0;
            hi_q      <= '0;
            edges_q   <= '0;
            to_q      <= '0;
            sat_q     <= 1'b0;
            tmo_q     <= 1'b0;
            satf_q    <= 1'b0;
            per_tot_q <= '0;
            hi_tot_q  <= '0;
        end else begin
            state_q   <= state_d;
            m1        <= mon_clk;
            m2        <= m1;
            m3        <= m2;
            per_q     <= per_d;
            hi_q      <= hi_d;
            edges_q   <= edges_d;
            to_q      <= to_d;
            sat_q     <= sat_d;
            tmo_q     <= tmo_d;
            satf_q    <= satf_d;
            per_tot_q <= per_tot_d;
            hi_tot_q  <= hi_tot_d;
        end
    end

    assign bus.busy         = (state_q == StArm) || (state_q == StMeas);
    assign bus.result_valid = (state_q == StDone);
    assign bus.period_total = per_tot_q;
    assign bus.high_total   = hi_tot_q;
    assign bus.timeout      = tmo_q;
    assign bus.saturated    = satf_q;
endmodule

// File: tb/tb_clock_ratio_meter.sv
// Self-checking bench for clock_ratio_meter: table of measurement runs with a result scoreboard,
// plus handshake and mid-run reset sequences.
module tb_clock_ratio_meter;
    typedef struct {
        int div;
        bit jit;
        int which;
        int exp_per;
        int hi_lo;
        int hi_hi;
        bit exp_to;
        bit exp_sat;
        int lat_mode;
    } vec_t;

    typedef struct {
        bit busy;
        bit valid;
        int per;
        int hi;
        bit to;
        bit sat;
    } obs_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic mon_clk = 1'b0;
    int   cyc = 0;
    logic tm1 = 1'b0, tm2 = 1'b0, tm3 = 1'b0;
    int   div = 4;
    bit   jit = 1'b0;
    int   hc = 0;
    bit   ph = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t vecs[5];

    clock_ratio_meter_if #(.CNT_W(16)) bif ();
    clock_ratio_meter_if #(.CNT_W(6))  bif6 ();

    clock_ratio_meter #(.CNT_W(16), .WIN_LOG2(2), .TO_W(12)) dut (
        .clk(clk), .resetb(resetb), .mon_clk(mon_clk), .bus(bif.slave)
    );
    clock_ratio_meter #(.CNT_W(6), .WIN_LOG2(2), .TO_W(12)) dut6 (
        .clk(clk), .resetb(resetb), .mon_clk(mon_clk), .bus(bif6.slave)
    );

    initial forever #5 clk = ~clk;

    // Reference synchronizer used to locate the rise that closes each window.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        tm1 <= mon_clk;
        tm2 <= tm1;
        tm3 <= tm2;
    end

    // Monitored clock in half-clk steps; jit alternates 1.0/2.0-cycle high phases (avg 50% at /3).
    initial forever begin
        @(clk);
        #1;
        if (div == 0) begin
            hc = 0;
            mon_clk = 1'b0;
        end else begin
            hc++;
            if (hc >= 2 * div) begin
                hc = 0;
                ph = ~ph;
            end
            mon_clk = (hc < (jit ? (ph ? 4 : 2) : div));
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, got hang, expected finish");
        $fatal(1);
    end

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 1) begin
            o.busy = bif6.busy;   o.valid = bif6.result_valid;
            o.per = int'(bif6.period_total); o.hi = int'(bif6.high_total);
            o.to = bif6.timeout;  o.sat = bif6.saturated;
        end else begin
            o.busy = bif.busy;    o.valid = bif.result_valid;
            o.per = int'(bif.period_total);  o.hi = int'(bif.high_total);
            o.to = bif.timeout;   o.sat = bif.saturated;
        end
        return o;
    endfunction

    task automatic set_in(input int which, input bit s, input bit a);
        if (which == 1) begin
            bif6.start = s; bif6.ack = a;
        end else begin
            bif.start = s;  bif.ack = a;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic start_meas(input int which, output int arm_cyc);
        obs_t o;
        @(negedge clk);
        set_in(which, 1'b1, 1'b0);
        @(negedge clk);
        set_in(which, 1'b0, 1'b0);
        arm_cyc = cyc;
        o = sample(which);
        check("busy one cycle after start", int'(o.busy), 1);
    endtask

    task automatic wait_valid(input int which, output bit got, output int rise_cyc);
        obs_t o;
        int   rises;
        rises = 0;
        got = 1'b0;
        rise_cyc = -1;
        for (int n = 0; n < 6000; n++) begin
            o = sample(which);
            if (o.valid) begin
                got = 1'b1;
                break;
            end
            if (tm2 && !tm3) begin
                rises++;
                if (rises == 5) rise_cyc = cyc;
            end
            @(negedge clk);
        end
        check("result_valid within cycle budget", int'(got), 1);
    endtask

    task automatic finish_row(input int which, input int arm_cyc, input int rise_cyc);
        vec_t e;
        obs_t o;
        if (exp_q.size() == 0) begin
            check("scoreboard has expected entry", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        o = sample(which);
        check($sformatf("period_total div=%0d", e.div), o.per, e.exp_per);
        check_rng($sformatf("high_total div=%0d", e.div), o.hi, e.hi_lo, e.hi_hi);
        check($sformatf("timeout div=%0d", e.div), int'(o.to), int'(e.exp_to));
        check($sformatf("saturated div=%0d", e.div), int'(o.sat), int'(e.exp_sat));
        check("busy low when result valid", int'(o.busy), 0);
        if (e.lat_mode == 1) check("valid one cycle after window rise", cyc, rise_cyc + 1);
        if (e.lat_mode == 2) check("timeout latency from ARM entry", cyc - arm_cyc, 4096);
    endtask

    task automatic do_ack(input int which, input int exp_per);
        obs_t o;
        set_in(which, 1'b0, 1'b1);
        @(negedge clk);
        set_in(which, 1'b0, 1'b0);
        o = sample(which);
        check("result_valid cleared after ack", int'(o.valid), 0);
        check("period_total kept after ack", o.per, exp_per);
    endtask

    task automatic run_row(input vec_t v);
        int arm_cyc, rise_cyc;
        bit got;
        div = v.div;
        jit = v.jit;
        repeat (40) @(negedge clk);
        exp_q.push_back(v);
        start_meas(v.which, arm_cyc);
        wait_valid(v.which, got, rise_cyc);
        if (got) begin
            finish_row(v.which, arm_cyc, rise_cyc);
            do_ack(v.which, v.exp_per);
        end else begin
            exp_q.delete();
        end
    endtask

    initial begin
        obs_t o;
        vec_t v;
        int   arm_cyc, rise_cyc, bad;
        bit   got;

        set_in(0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        o = sample(0);
        check("reset busy", int'(o.busy), 0);
        check("reset result_valid", int'(o.valid), 0);
        check("reset period_total", o.per, 0);
        check("reset high_total", o.hi, 0);
        check("reset timeout", int'(o.to), 0);
        check("reset saturated", int'(o.sat), 0);
        resetb = 1'b1;

        //        div jit dut per  hlo hhi to sat lat
        vecs[0] = '{4,  0,  0,  16,  8,  8, 0, 0, 1};
        vecs[1] = '{3,  1,  0,  12,  5,  7, 0, 0, 1};
        vecs[2] = '{6,  0,  0,  24, 12, 12, 0, 0, 1};
        vecs[3] = '{0,  0,  0,   0,  0,  0, 1, 0, 2};
        vecs[4] = '{32, 0,  1,  63, 63, 63, 0, 1, 0};
        for (int i = 0; i < 5; i++) run_row(vecs[i]);

        // Handshake: stray starts during MEAS/DONE, stability, ack+start collision.
        div = 4;
        jit = 1'b0;
        repeat (40) @(negedge clk);
        v = vecs[0];
        v.lat_mode = 0;
        exp_q.push_back(v);
        start_meas(0, arm_cyc);
        repeat (10) @(negedge clk);
        set_in(0, 1'b1, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        o = sample(0);
        check("busy kept through start in MEAS", int'(o.busy), 1);
        wait_valid(0, got, rise_cyc);
        finish_row(0, arm_cyc, rise_cyc);
        set_in(0, 1'b1, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        o = sample(0);
        check("valid kept through start in DONE", int'(o.valid), 1);
        check("busy stays low after start in DONE", int'(o.busy), 0);
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            o = sample(0);
            if (!o.valid || o.busy || o.per != 16 || o.hi != 8 || o.to || o.sat) bad++;
        end
        check("outputs stable while unacked", bad, 0);
        set_in(0, 1'b1, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        o = sample(0);
        check("valid cleared by ack with start", int'(o.valid), 0);
        repeat (5) @(negedge clk);
        o = sample(0);
        check("no new run from start with ack", int'(o.busy), 0);

        // Asynchronous reset in the middle of a measurement.
        start_meas(0, arm_cyc);
        repeat (8) @(negedge clk);
        o = sample(0);
        check("busy before mid-run reset", int'(o.busy), 1);
        resetb = 1'b0;
        #1;
        o = sample(0);
        check("async reset busy", int'(o.busy), 0);
        check("async reset result_valid", int'(o.valid), 0);
        check("async reset period_total", o.per, 0);
        check("async reset high_total", o.hi, 0);
        check("async reset timeout", int'(o.to), 0);
        check("async reset saturated", int'(o.sat), 0);
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        run_row(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
